// File: rtl/il1_refill_unit_pkg.sv
// Shared IL1 refill types and default geometry.
package RVS192_package;

    localparam int unsigned RVS_PC_LENGTH   = 32;
    localparam int unsigned RVS_INST_LENGTH = 32;
    localparam int unsigned RVS_LINE_WORDS  = 4;
    localparam int unsigned RVS_ICACHE_WAY  = 4;
    localparam int unsigned RVS_ACK_TIMEOUT = 64;

    localparam int unsigned BYTE_OFFSET = 2;
    localparam int unsigned WORD_OFFSET = $clog2(RVS_LINE_WORDS);

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_REQ,
        RF_FILL,
        RF_UPD
    } rf_state_e;

endpackage

// File: rtl/il1_refill_unit_line_buffer.sv
// Line assembly buffer: one word written per L2 beat, whole line visible, registered word read.
module il1_line_buffer #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(WORDS)-1:0]   wr_idx,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(WORDS)-1:0]   rd_idx,
    output logic [WORDS*WIDTH-1:0]     line,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WORDS-1:0][WIDTH-1:0] mem;

    // Read forwards the word being written so the last beat is visible in the next cycle.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
    end

    assign line = mem;

endmodule

// File: rtl/il1_refill_unit.sv
// IL1 miss refill engine: requests a line from L2, assembles the beats, then updates IL1 once.
module il1_refill_unit
    import RVS192_package::*;
#(
    parameter int unsigned PC_LENGTH   = RVS_PC_LENGTH,
    parameter int unsigned INST_LENGTH = RVS_INST_LENGTH,
    parameter int unsigned LINE_WORDS  = RVS_LINE_WORDS,
    parameter int unsigned ICACHE_WAY  = RVS_ICACHE_WAY,
    parameter int unsigned ACK_TIMEOUT = RVS_ACK_TIMEOUT
) (
    input  logic                              clk_l1,
    input  logic                              rst_n,
    input  logic                              update_trigger,
    input  logic [PC_LENGTH-1:0]              pc_up,
    input  logic [ICACHE_WAY-1:0]             replace_way,
    output logic                              l2_req,
    output logic [PC_LENGTH-1:0]              l2_addr,
    input  logic                              l2_ack,
    input  logic                              l2_rvalid,
    input  logic [INST_LENGTH-1:0]            l2_rdata,
    output logic                              update,
    output logic [LINE_WORDS*INST_LENGTH-1:0] update_line,
    output logic [INST_LENGTH-1:0]            update_inst,
    output logic [ICACHE_WAY-1:0]             update_way,
    output logic                              refill_busy,
    output logic                              refill_retry
);

    localparam int unsigned WO         = $clog2(LINE_WORDS);
    localparam int unsigned TW         = $clog2(ACK_TIMEOUT);
    localparam int unsigned LINE_BYTES = LINE_WORDS << BYTE_OFFSET;
    localparam logic [WO-1:0] LAST_BEAT = WO'(LINE_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

    rf_state_e             state_q, state_d;
    logic [WO-1:0]         beat_q, beat_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [WO-1:0]         rd_idx_q;
    logic [ICACHE_WAY-1:0] way_q;
    logic                  wr_en;
    logic                  retry_d;
    logic                  capture;

    // Next-state, beat/timeout counters and buffer write strobe.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q + TW'(1);
        wr_en   = 1'b0;
        retry_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            RF_IDLE: begin
                tmo_d = '0;
                if (update_trigger) begin
                    capture = 1'b1;
                    beat_d  = '0;
                    state_d = RF_REQ;
                end
            end
            RF_REQ: begin
                if (l2_ack) begin
                    tmo_d   = '0;
                    state_d = RF_FILL;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    beat_d  = '0;
                    retry_d = 1'b1;
                end
            end
            RF_FILL: begin
                if (l2_rvalid) begin
                    wr_en  = 1'b1;
                    tmo_d  = '0;
                    beat_d = beat_q + WO'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = RF_UPD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    beat_d  = '0;
                    retry_d = 1'b1;
                    state_d = RF_REQ;
                end
            end
            RF_UPD: begin
                tmo_d   = '0;
                state_d = RF_IDLE;
            end
            default: begin
                tmo_d   = '0;
                state_d = RF_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs decoded from the next state.
    always_ff @(negedge clk_l1) begin
        if (!rst_n) begin
            state_q      <= RF_IDLE;
            beat_q       <= '0;
            tmo_q        <= '0;
            l2_req       <= 1'b0;
            update       <= 1'b0;
            update_way   <= '0;
            refill_busy  <= 1'b0;
            refill_retry <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            l2_req       <= (state_d == RF_REQ);
            update       <= (state_d == RF_UPD);
            update_way   <= (state_d == RF_UPD) ? way_q : '0;
            refill_busy  <= (state_d != RF_IDLE);
            refill_retry <= retry_d;
        end
    end

    // Miss context captured once per refill; the L2 address is line aligned.
    always_ff @(negedge clk_l1) begin
        if (capture) begin
            l2_addr  <= pc_up & ~PC_LENGTH'(LINE_BYTES - 1);
            rd_idx_q <= WO'(pc_up >> BYTE_OFFSET);
            way_q    <= replace_way;
        end
    end

    il1_line_buffer #(
        .WORDS (LINE_WORDS),
        .WIDTH (INST_LENGTH)
    ) u_line_buffer (
        .clk     (clk_l1),
        .wr_en   (wr_en),
        .wr_idx  (beat_q),
        .wr_data (l2_rdata),
        .rd_idx  (rd_idx_q),
        .line    (update_line),
        .rd_data (update_inst)
    );

endmodule

// File: tb/tb_il1_refill_unit.sv
// Scoreboard bench for il1_refill_unit: directed refills, expected updates queued and checked by a monitor.
module tb_il1_refill_unit;

    logic         clk_l1 = 1'b0;
    logic         rst_n;
    logic         update_trigger;
    logic [31:0]  pc_up;
    logic [3:0]   replace_way;
    logic         l2_req;
    logic [31:0]  l2_addr;
    logic         l2_ack;
    logic         l2_rvalid;
    logic [31:0]  l2_rdata;
    logic         update;
    logic [127:0] update_line;
    logic [31:0]  update_inst;
    logic [3:0]   update_way;
    logic         refill_busy;
    logic         refill_retry;

    typedef struct {
        logic [127:0] line;
        logic [31:0]  inst;
        logic [3:0]   way;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_upd   = 0;

    always #5 clk_l1 = ~clk_l1;

    il1_refill_unit dut (
        .clk_l1         (clk_l1),
        .rst_n          (rst_n),
        .update_trigger (update_trigger),
        .pc_up          (pc_up),
        .replace_way    (replace_way),
        .l2_req         (l2_req),
        .l2_addr        (l2_addr),
        .l2_ack         (l2_ack),
        .l2_rvalid      (l2_rvalid),
        .l2_rdata       (l2_rdata),
        .update         (update),
        .update_line    (update_line),
        .update_inst    (update_inst),
        .update_way     (update_way),
        .refill_busy    (refill_busy),
        .refill_retry   (refill_retry)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_l1);
        #1;
    endtask

    task automatic push(input logic [127:0] line, input logic [31:0] inst, input logic [3:0] way);
        exp_t e;
        e.line = line;
        e.inst = inst;
        e.way  = way;
        exp_q.push_back(e);
    endtask

    task automatic trigger(input logic [31:0] pc, input logic [3:0] way);
        update_trigger = 1'b1;
        pc_up          = pc;
        replace_way    = way;
        tick();
        update_trigger = 1'b0;
        pc_up          = '0;
        replace_way    = '0;
    endtask

    task automatic ack();
        l2_ack = 1'b1;
        tick();
        l2_ack = 1'b0;
    endtask

    task automatic send_beats(input logic [127:0] ln, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            l2_rvalid = 1'b1;
            l2_rdata  = ln[i*32 +: 32];
            tick();
            l2_rvalid = 1'b0;
            l2_rdata  = '0;
            repeat (gap) tick();
        end
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(posedge clk_l1) begin : monitor
        exp_t e;
        if (update === 1'b1) begin
            n_upd++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_update: got update with line %h, expected none", update_line);
            end else begin
                e = exp_q.pop_front();
                chk("update_line", update_line, e.line);
                chk("update_inst", 128'(update_inst), 128'(e.inst));
                chk("update_way", 128'(update_way), 128'(e.way));
            end
        end
    end

    initial begin : stim
        logic [127:0] line_a, line_c, line_d, line_e, line_b;
        int k;
        line_a = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        line_c = {32'hCCCC_0003, 32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};
        line_d = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        line_e = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000};
        line_b = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};

        rst_n = 1'b0; update_trigger = 1'b0; pc_up = '0; replace_way = '0;
        l2_ack = 1'b0; l2_rvalid = 1'b1; l2_rdata = 32'h1234_5678;

        // 1: reset with a stray beat present
        repeat (3) tick();
        chk("rst_l2_req", 128'(l2_req), 128'd0);
        chk("rst_update", 128'(update), 128'd0);
        chk("rst_busy", 128'(refill_busy), 128'd0);
        chk("rst_retry", 128'(refill_retry), 128'd0);
        chk("rst_way", 128'(update_way), 128'd0);
        rst_n = 1'b1; l2_rvalid = 1'b0; l2_rdata = '0;
        repeat (2) tick();

        // 2: minimum-latency refill, critical word 2
        push(line_a, 32'hAAAA_0002, 4'b0100);
        trigger(32'h0000_1238, 4'b0100);
        chk("t2_l2_req", 128'(l2_req), 128'd1);
        chk("t2_l2_addr", 128'(l2_addr), 128'h1230);
        chk("t2_busy", 128'(refill_busy), 128'd1);
        ack();
        chk("t2_req_drop", 128'(l2_req), 128'd0);
        send_beats(line_a, 0, 2, 0);
        chk("t2_update_early", 128'(update), 128'd0);
        send_beats(line_a, 3, 3, 0);
        chk("t2_update_at_6", 128'(update), 128'd1);
        tick();
        chk("t2_update_one_cycle", 128'(update), 128'd0);
        chk("t2_busy_after", 128'(refill_busy), 128'd0);
        chk("t2_way_cleared", 128'(update_way), 128'd0);
        repeat (2) tick();

        // 3: delayed ack and gapped beats
        push(line_c, 32'hCCCC_0001, 4'b0001);
        trigger(32'h0000_2004, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            chk("t3_req_held", 128'(l2_req), 128'd1);
            tick();
        end
        chk("t3_l2_addr", 128'(l2_addr), 128'h2000);
        ack();
        send_beats(line_c, 0, 3, 2);
        repeat (3) tick();

        // 4: ack timeout then retry on the same address
        push(line_d, 32'hDDDD_0002, 4'b1000);
        trigger(32'h0000_3008, 4'b1000);
        k = 0;
        while (refill_retry !== 1'b1 && k < 80) begin
            tick();
            k++;
        end
        chk("t4_retry_latency", 128'(k), 128'd64);
        chk("t4_req_kept", 128'(l2_req), 128'd1);
        chk("t4_addr_kept", 128'(l2_addr), 128'h3000);
        tick();
        chk("t4_retry_pulse", 128'(refill_retry), 128'd0);
        ack();
        send_beats(line_d, 0, 3, 0);
        repeat (2) tick();

        // 5: trigger during FILL and stray beats in IDLE are ignored
        push(line_e, 32'hEEEE_0003, 4'b0010);
        trigger(32'h0000_010C, 4'b0010);
        chk("t5_l2_addr", 128'(l2_addr), 128'h100);
        ack();
        send_beats(line_e, 0, 1, 0);
        trigger(32'h0000_5000, 4'b0001);
        send_beats(line_e, 2, 3, 0);
        repeat (2) tick();
        l2_rvalid = 1'b1; l2_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        l2_rvalid = 1'b0; l2_rdata = '0;
        chk("t5_no_extra_busy", 128'(refill_busy), 128'd0);
        chk("t5_no_req", 128'(l2_req), 128'd0);
        chk("t5_line_unchanged", update_line, line_e);
        tick();

        // 6: reset mid-refill, then a clean refill at 0x40
        trigger(32'h0000_0080, 4'b0100);
        ack();
        send_beats(line_a, 0, 1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_idle_busy", 128'(refill_busy), 128'd0);
        chk("t6_idle_req", 128'(l2_req), 128'd0);
        l2_rvalid = 1'b1; l2_rdata = 32'h5555_5555;
        repeat (2) tick();
        l2_rvalid = 1'b0; l2_rdata = '0;
        push(line_b, 32'hBBBB_0000, 4'b0001);
        trigger(32'h0000_0040, 4'b0001);
        chk("t6_l2_addr", 128'(l2_addr), 128'h40);
        ack();
        send_beats(line_b, 0, 3, 0);
        repeat (3) tick();

        chk("update_count", 128'(n_upd), 128'd5);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
